// File: rtl/display_ram_arbiter_if.sv
// Bus bundle between the display RAM arbiter, its requesters (video fetch, CPU) and the RAM.
// slave = arbiter side, master = requester/RAM side.
interface display_ram_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
);
   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic [DATA_W-1:0] vid_data;
   logic              vid_valid;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;
   logic              cpu_starve;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
      output vid_data, vid_valid, cpu_rdata, cpu_ack, cpu_starve, ram_addr, ram_we, ram_wdata
   );

   modport master (
      output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
      input  vid_data, vid_valid, cpu_rdata, cpu_ack, cpu_starve, ram_addr, ram_we, ram_wdata
   );
endinterface

// File: rtl/display_ram_arbiter.sv
// Single-port display RAM arbiter: video fetch has strict priority with a fixed 2-edge
// read latency; the CPU gets every slot video leaves free, one access in flight at a time.
module display_ram_arbiter #(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 8,
   parameter int STARVE_LIM = 64
) (
   input  logic                  clk_pixel,
   input  logic                  reset_n,
   display_ram_arbiter_if.slave  bus
);
   localparam logic [1:0] C_IDLE   = 2'd0;
   localparam logic [1:0] C_WAIT   = 2'd1;
   localparam logic [1:0] C_ISSUED = 2'd2;
   localparam logic [1:0] C_DATA   = 2'd3;

   // Tag bit 1 marks a CPU slot, so cpu_ack is simply tag2[1].
   localparam logic [1:0] T_NONE = 2'd0;
   localparam logic [1:0] T_VID  = 2'd1;
   localparam logic [1:0] T_CPUR = 2'd2;
   localparam logic [1:0] T_CPUW = 2'd3;

   localparam int              CNT_W = $clog2(STARVE_LIM + 1);
   localparam logic [CNT_W-1:0] LIM  = CNT_W'(STARVE_LIM);

   logic [1:0]        state_q, state_d;
   logic [1:0]        tag1_q, tag1_d, tag2_q;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic              ram_we_q, ram_we_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic [DATA_W-1:0] vid_data_q, vid_data_d;
   logic              vid_valid_q, vid_valid_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              starve_q, starve_d;
   logic              grant_cpu;

   always_comb begin
      grant_cpu   = !bus.vid_req && (state_q == C_WAIT);
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      tag1_d      = T_NONE;
      if (bus.vid_req) begin
         ram_addr_d = bus.vid_addr;
         tag1_d     = T_VID;
      end else if (grant_cpu) begin
         ram_addr_d  = bus.cpu_addr;
         ram_we_d    = bus.cpu_we;
         ram_wdata_d = bus.cpu_wdata;
         tag1_d      = bus.cpu_we ? T_CPUW : T_CPUR;
      end

      vid_valid_d = (tag2_q == T_VID);
      vid_data_d  = vid_valid_d ? bus.ram_rdata : vid_data_q;
      cpu_ack_d   = tag2_q[1];
      cpu_rdata_d = (tag2_q == T_CPUR) ? bus.ram_rdata : cpu_rdata_q;

      state_d = state_q;
      case (state_q)
         // cpu_ack_q high means the requester has not yet seen the ack; its cpu_req is stale.
         C_IDLE:   if (bus.cpu_req && !cpu_ack_q) state_d = C_WAIT;
         C_WAIT:   if (grant_cpu) state_d = C_ISSUED;
         C_ISSUED: state_d = C_DATA;
         C_DATA:   state_d = C_IDLE;
         default:  state_d = C_IDLE;
      endcase

      cnt_d = cnt_q;
      if (state_q == C_WAIT && bus.vid_req) begin
         if (cnt_q != LIM) cnt_d = cnt_q + 1'b1;
      end else if (grant_cpu) begin
         cnt_d = '0;
      end
      starve_d = starve_q | (cnt_d == LIM);
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= C_IDLE;
         tag1_q      <= T_NONE;
         tag2_q      <= T_NONE;
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
         vid_data_q  <= '0;
         vid_valid_q <= 1'b0;
         cpu_rdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         cnt_q       <= '0;
         starve_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         tag1_q      <= tag1_d;
         tag2_q      <= tag1_q;
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
         vid_data_q  <= vid_data_d;
         vid_valid_q <= vid_valid_d;
         cpu_rdata_q <= cpu_rdata_d;
         cpu_ack_q   <= cpu_ack_d;
         cnt_q       <= cnt_d;
         starve_q    <= starve_d;
      end
   end

   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_we     = ram_we_q;
   assign bus.ram_wdata  = ram_wdata_q;
   assign bus.vid_data   = vid_data_q;
   assign bus.vid_valid  = vid_valid_q;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.cpu_ack    = cpu_ack_q;
   assign bus.cpu_starve = starve_q;
endmodule

// File: tb/tb_display_ram_arbiter.sv
// Scoreboard bench: the driver predicts each vid_valid/cpu_ack (edge + data) from a transaction-level
// model of grants and RAM contents; a negedge monitor pops and compares.
module tb_display_ram_arbiter;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;
   localparam int LIM    = 64;

   logic clk_pixel = 1'b0;
   logic reset_n   = 1'b1;
   logic load_mem  = 1'b0;
   always #5 clk_pixel = ~clk_pixel;

   display_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   display_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(LIM)) dut (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .bus       (bus)
   );

   function automatic logic [7:0] init_val(input int a);
      if (a == 'h123) return 8'hA5;
      return 8'(a + 'h40);
   endfunction

   // 2K synchronous RAM; upper address bits ignored.
   logic [7:0] ram [0:2047];
   always @(posedge clk_pixel) begin
      if (load_mem) begin
         for (int i = 0; i < 2048; i++) ram[i] <= init_val(i);
      end else begin
         if (bus.ram_we) ram[bus.ram_addr[10:0]] <= bus.ram_wdata;
         bus.ram_rdata <= ram[bus.ram_addr[10:0]];
      end
   end

   typedef struct { int e; logic [7:0] d; } exp_t;
   exp_t vid_q[$];
   exp_t cpu_q[$];

   int   n_cmp = 0, n_bad = 0;
   int   cyc = 0;
   bit   chk_en = 0;

   // reference model state
   logic [7:0] ref_mem [0:2047];
   int   cpu_ph;        // 0 none, 1 pending, 2 in flight
   int   ack_e;
   int   starve_cnt;
   bit   starve_exp;
   logic [7:0] last_rd;
   bit   cpu_out;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk_pixel) begin
      if (chk_en) begin
         bit   ev, ec;
         exp_t x;
         ev = (vid_q.size() > 0) && (vid_q[0].e == cyc);
         check("vid_valid", bus.vid_valid, ev);
         if (ev) begin
            x = vid_q.pop_front();
            if (bus.vid_valid) check("vid_data", bus.vid_data, x.d);
         end
         ec = (cpu_q.size() > 0) && (cpu_q[0].e == cyc);
         check("cpu_ack", bus.cpu_ack, ec);
         if (ec) begin
            x = cpu_q.pop_front();
            if (bus.cpu_ack) check("cpu_rdata", bus.cpu_rdata, x.d);
         end
         check("cpu_starve", bus.cpu_starve, starve_exp);
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
      vid_q.delete();
      cpu_q.delete();
      cpu_ph = 0; ack_e = -10; starve_cnt = 0; starve_exp = 0; last_rd = 8'h00;
      cyc = 0;
   endtask

   // Accesses complete in grant order; a grant at edge n is reported at edge n+2.
   task automatic model_edge();
      if (bus.vid_req) vid_q.push_back('{e: cyc + 2, d: ref_mem[bus.vid_addr[10:0]]});
      if (cpu_ph == 2 && cyc == ack_e) begin
         cpu_ph = 0;
      end else if (cpu_ph == 1) begin
         if (!bus.vid_req) begin
            if (bus.cpu_we) ref_mem[bus.cpu_addr[10:0]] = bus.cpu_wdata;
            else            last_rd = ref_mem[bus.cpu_addr[10:0]];
            cpu_q.push_back('{e: cyc + 2, d: last_rd});
            ack_e = cyc + 2; cpu_ph = 2; starve_cnt = 0;
         end else begin
            if (starve_cnt < LIM) starve_cnt++;
            if (starve_cnt == LIM) starve_exp = 1;
         end
      end else if (cpu_ph == 0 && bus.cpu_req && cyc != ack_e + 1) begin
         cpu_ph = 1;
      end
   endtask

   task automatic step();
      @(posedge clk_pixel);
      cyc++;
      model_edge();
      #1;
      if (cpu_out && bus.cpu_ack) begin
         cpu_out = 0;
         bus.cpu_req = 1'b0;
      end
   endtask

   task automatic cpu_issue(input logic we, input logic [12:0] a, input logic [7:0] d);
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
      cpu_out = 1;
   endtask

   task automatic wait_cpu(input int bound);
      int n = 0;
      while (cpu_out && n < bound) begin step(); n++; end
      if (cpu_out) check("cpu_timeout", 1, 0);
   endtask

   task automatic reset_checks();
      check("rst_ram_addr", bus.ram_addr, 0);
      check("rst_ram_we", bus.ram_we, 0);
      check("rst_ram_wdata", bus.ram_wdata, 0);
      check("rst_vid_data", bus.vid_data, 0);
      check("rst_vid_valid", bus.vid_valid, 0);
      check("rst_cpu_rdata", bus.cpu_rdata, 0);
      check("rst_cpu_ack", bus.cpu_ack, 0);
      check("rst_cpu_starve", bus.cpu_starve, 0);
   endtask

   task automatic do_reset();
      chk_en = 0;
      reset_n = 1'b0;
      bus.vid_req = 0; bus.vid_addr = '0; bus.cpu_req = 0; bus.cpu_we = 0;
      bus.cpu_addr = '0; bus.cpu_wdata = '0; cpu_out = 0;
      #1 reset_checks();
      load_mem = 1'b1;
      @(posedge clk_pixel);
      @(posedge clk_pixel);
      load_mem = 1'b0;
      model_reset();
      @(negedge clk_pixel);
      reset_n = 1'b1;
      chk_en = 1;
   endtask

   initial begin
      #2 do_reset();

      // back-to-back video fetch 0..31
      for (int a = 0; a < 32; a++) begin
         bus.vid_req = 1'b1; bus.vid_addr = 13'(a);
         step();
      end
      bus.vid_req = 1'b0;
      repeat (3) step();

      // CPU read, video idle
      cpu_issue(1'b0, 13'h0123, 8'h00);
      wait_cpu(20);
      step();

      // CPU write followed by video read of the same address one cycle after the grant
      cpu_issue(1'b1, 13'h0010, 8'h3C);
      step(); step();
      bus.vid_req = 1'b1; bus.vid_addr = 13'h0010;
      step();
      bus.vid_req = 1'b0;
      wait_cpu(20);
      repeat (2) step();

      // CPU blocked by 10 video cycles
      cpu_issue(1'b0, 13'h0005, 8'h00);
      for (int i = 0; i < 10; i++) begin
         bus.vid_req = 1'b1; bus.vid_addr = 13'($urandom);
         step();
      end
      bus.vid_req = 1'b0;
      wait_cpu(20);
      repeat (2) step();

      // cpu_req held continuously
      for (int i = 0; i < 40; i++) begin
         if (!cpu_out) cpu_issue(1'($urandom), 13'($urandom), 8'($urandom));
         step();
      end
      wait_cpu(20);
      repeat (3) step();

      // random mix
      for (int i = 0; i < 1500; i++) begin
         bus.vid_req  = ($urandom_range(0, 99) < 40);
         bus.vid_addr = 13'($urandom);
         if (!cpu_out && $urandom_range(0, 3) == 0)
            cpu_issue(1'($urandom), 13'($urandom_range(0, 63)), 8'($urandom));
         step();
      end
      bus.vid_req = 1'b0;
      wait_cpu(20);
      repeat (3) step();

      // reset mid-run with traffic in flight
      for (int i = 0; i < 20; i++) begin
         bus.vid_req  = ($urandom_range(0, 1) == 1);
         bus.vid_addr = 13'($urandom);
         if (!cpu_out) cpu_issue(1'($urandom), 13'($urandom), 8'($urandom));
         step();
      end
      #2 do_reset();
      repeat (8) step();

      // starvation: 70 denied cycles
      cpu_issue(1'b0, 13'h0123, 8'h00);
      for (int i = 0; i < 70; i++) begin
         bus.vid_req = 1'b1; bus.vid_addr = 13'($urandom);
         step();
      end
      bus.vid_req = 1'b0;
      wait_cpu(20);
      repeat (5) step();
      check("starve_sticky", bus.cpu_starve, 1);

      check("vid_q_empty", vid_q.size(), 0);
      check("cpu_q_empty", cpu_q.size(), 0);
      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
